// File: rtl/capp_array.sv
// Associative (content-addressable) word array with a tag register for parallel masked search.
// Each command runs through IDLE -> EXEC -> RESP, and a registered response is presented in RESP.
module capp_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100,
    localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cmd_mask,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [AW-1:0]    rsp_addr,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CW-1:0]    rsp_count,
    output logic [DEPTH-1:0] tags
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [2:0] OP_LOAD = 3'd0, OP_SEARCH = 3'd1, OP_SEARCH_AND = 3'd2,
                           OP_WRITE_TAGGED = 3'd3, OP_READ_FIRST = 3'd4,
                           OP_SELECT_FIRST = 3'd5, OP_CLEAR_TAGS = 3'd6, OP_NOP = 3'd7;
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    state_t           state_r;
    logic [2:0]       op_r;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] store_r [DEPTH];
    logic [WIDTH-1:0] store_nxt_s [DEPTH];
    logic [DEPTH-1:0] tags_r;
    logic [DEPTH-1:0] tags_nxt_s;
    logic [DEPTH-1:0] match_s;
    logic [AW-1:0]    first_s;
    logic [CW-1:0]    count_s;
    logic             hit_s;

    assign tags = tags_r;

    // Parallel masked compare of every stored word against the captured key
    always_comb begin
        match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = (((store_r[i] ^ data_r) & mask_r) == '0);
        end
    end

    // Post-operation store and tag contents, committed on the edge leaving EXEC
    always_comb begin
        tags_nxt_s  = tags_r;
        store_nxt_s = store_r;
        case (op_r)
            OP_LOAD: begin
                if ({1'b0, addr_r} < DEPTH_W) begin
                    store_nxt_s[addr_r] = (store_r[addr_r] & ~mask_r) | (data_r & mask_r);
                end else begin
                    store_nxt_s = store_r;
                end
            end
            OP_SEARCH:       tags_nxt_s = match_s;
            OP_SEARCH_AND:   tags_nxt_s = tags_r & match_s;
            OP_WRITE_TAGGED: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (tags_r[i]) begin
                        store_nxt_s[i] = (store_r[i] & ~mask_r) | (data_r & mask_r);
                    end else begin
                        store_nxt_s[i] = store_r[i];
                    end
                end
            end
            // Two's-complement trick isolates the lowest set tag
            OP_SELECT_FIRST: tags_nxt_s = tags_r & (~tags_r + {{(DEPTH-1){1'b0}}, 1'b1});
            OP_CLEAR_TAGS:   tags_nxt_s = '0;
            OP_READ_FIRST:   tags_nxt_s = tags_r;
            OP_NOP:          tags_nxt_s = tags_r;
            default:         tags_nxt_s = tags_r;
        endcase
    end

    // Lowest tagged index and population count of the post-operation tags
    always_comb begin
        first_s = '0;
        count_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tags_nxt_s[i]) begin
                first_s = AW'(i);
                count_s = count_s + CW'(1);
            end else begin
                count_s = count_s;
            end
        end
        hit_s = |tags_nxt_s;
    end

    // Command FSM, storage update and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_count <= '0;
            tags_r    <= '0;
            store_r   <= '{default: '0};
            op_r      <= OP_NOP;
            addr_r    <= '0;
            data_r    <= '0;
            mask_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        op_r      <= cmd_op;
                        addr_r    <= cmd_addr;
                        data_r    <= cmd_data;
                        mask_r    <= cmd_mask;
                        cmd_ready <= 1'b0;
                        state_r   <= EXEC;
                    end else begin
                        cmd_ready <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                EXEC: begin
                    store_r   <= store_nxt_s;
                    tags_r    <= tags_nxt_s;
                    rsp_hit   <= hit_s;
                    rsp_addr  <= first_s;
                    rsp_data  <= hit_s ? store_nxt_s[first_s] : '0;
                    rsp_count <= count_s;
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capp_array.sv
// Directed bench for capp_array: vector table of commands with expected responses,
// plus hand-written sequences for reset, back-to-back throughput and abort.
module tb_capp_array;
    localparam int WIDTH = 32;
    localparam int DEPTH = 100;
    localparam int AW    = 7;
    localparam int CW    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] cmd_mask;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [AW-1:0]    rsp_addr;
    logic [WIDTH-1:0] rsp_data;
    logic [CW-1:0]    rsp_count;
    logic [DEPTH-1:0] tags;

    capp_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_count(rsp_count), .tags(tags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] mask;
        logic             hit;
        logic [AW-1:0]    eaddr;
        logic [WIDTH-1:0] edata;
        logic [CW-1:0]    ecount;
        logic [DEPTH-1:0] etags;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] a,
                                input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m,
                                input logic h, input logic [AW-1:0] ea,
                                input logic [WIDTH-1:0] ed, input logic [CW-1:0] ec,
                                input logic [DEPTH-1:0] et);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.mask = m;
        v.hit = h; v.eaddr = ea; v.edata = ed; v.ecount = ec; v.etags = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command from a negedge; returns at the negedge where rsp_valid is seen.
    // Command inputs are scrambled right after the accept edge to show they are ignored.
    task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        int w;
        int lat;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 128'(cmd_ready), 128'(1'b1));
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd1; cmd_addr = ~a; cmd_data = ~d; cmd_mask = '0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 128'(lat), 128'(2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd7; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;

        vecs.push_back(mk(3'd0, 7'd0, 32'd456,  ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd1, 32'd457,  ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd2, 32'd1000, ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd3, 32'd1000, ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd4, 32'd457,  ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd1, 7'd0, 32'd457,  ONES, 1'b1, 7'd1, 32'd457, 7'd2, DEPTH'(5'b10010)));
        vecs.push_back(mk(3'd5, 7'd0, 32'd0,    32'd0, 1'b1, 7'd1, 32'd457, 7'd1, DEPTH'(5'b00010)));
        vecs.push_back(mk(3'd4, 7'd0, 32'd0,    32'd0, 1'b1, 7'd1, 32'd457, 7'd1, DEPTH'(5'b00010)));
        vecs.push_back(mk(3'd1, 7'd0, 32'd1000, ONES, 1'b1, 7'd2, 32'd1000, 7'd2, DEPTH'(5'b01100)));
        vecs.push_back(mk(3'd3, 7'd0, 32'd7,    32'hF, 1'b1, 7'd2, 32'h3E7, 7'd2, DEPTH'(5'b01100)));
        vecs.push_back(mk(3'd1, 7'd0, 32'd1000, ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd1, 7'd0, 32'd0,    32'd0, 1'b1, 7'd0, 32'd456, 7'd100, {DEPTH{1'b1}}));
        vecs.push_back(mk(3'd2, 7'd0, 32'd456,  ONES, 1'b1, 7'd0, 32'd456, 7'd1, DEPTH'(1'b1)));
        vecs.push_back(mk(3'd6, 7'd0, 32'd0,    32'd0, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd127, 32'hDEAD, ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd1, 7'd0, 32'hDEAD, ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd0, 7'd5, ONES,     32'hFF00, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd1, 7'd0, 32'hFF00, ONES, 1'b1, 7'd5, 32'hFF00, 7'd1, DEPTH'(6'b100000)));
        vecs.push_back(mk(3'd6, 7'd0, 32'd0,    32'd0, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd3, 7'd0, 32'd0,    ONES, 1'b0, 7'd0, 32'd0, 7'd0, '0));
        vecs.push_back(mk(3'd1, 7'd0, 32'hFF00, ONES, 1'b1, 7'd5, 32'hFF00, 7'd1, DEPTH'(6'b100000)));
        vecs.push_back(mk(3'd7, 7'd0, 32'd0,    32'd0, 1'b1, 7'd5, 32'hFF00, 7'd1, DEPTH'(6'b100000)));
        vecs.push_back(mk(3'd1, 7'd0, 32'd0,    ONES, 1'b1, 7'd6, 32'd0, 7'd94, {{(DEPTH-6){1'b1}}, 6'b0}));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 128'(cmd_ready), 128'(1'b1));
        check("reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("reset_rsp_hit", 128'(rsp_hit), 128'(1'b0));
        check("reset_rsp_count", 128'(rsp_count), 128'(0));
        check("reset_rsp_data", 128'(rsp_data), 128'(0));
        check("reset_tags", 128'(tags), 128'(0));

        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask);
            check($sformatf("v%0d_hit", i),   128'(rsp_hit),   128'(vecs[i].hit));
            check($sformatf("v%0d_addr", i),  128'(rsp_addr),  128'(vecs[i].eaddr));
            check($sformatf("v%0d_data", i),  128'(rsp_data),  128'(vecs[i].edata));
            check($sformatf("v%0d_count", i), 128'(rsp_count), 128'(vecs[i].ecount));
            check($sformatf("v%0d_tags", i),  128'(tags),      128'(vecs[i].etags));
        end

        // Response fields hold after the strobe drops
        @(negedge clk);
        check("hold_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("hold_rsp_count", 128'(rsp_count), 128'(94));
        check("hold_rsp_addr",  128'(rsp_addr),  128'(6));

        // Back-to-back: cmd_valid held high with NOPs
        cmd_valid = 1'b1; cmd_op = 3'd7;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("thru%0d_ready", k), 128'(cmd_ready), 128'((k % 3) == 0));
            check($sformatf("thru%0d_rsp", k),   128'(rsp_valid), 128'((k % 3) == 2));
            @(negedge clk);
        end
        cmd_valid = 1'b0;

        // Reset during EXEC of LOAD 5 to word 9 abandons the command
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 7'd9; cmd_data = 32'd5; cmd_mask = ONES;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check("abort_tags", 128'(tags), 128'(0));
        check("abort_rsp_count", 128'(rsp_count), 128'(0));
        // Reset wins over a simultaneous command
        cmd_valid = 1'b1;
        @(negedge clk);
        check("rst_prio_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        rst = 1'b0; cmd_valid = 1'b0;
        check("post_rst_ready", 128'(cmd_ready), 128'(1'b1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("no_rsp%0d", k), 128'(rsp_valid), 128'(1'b0));
        end
        do_cmd(3'd1, 7'd0, 32'd5, ONES);
        check("abort_word9_hit", 128'(rsp_hit), 128'(1'b0));
        do_cmd(3'd1, 7'd0, 32'd0, ONES);
        check("abort_zero_count", 128'(rsp_count), 128'(DEPTH));
        check("abort_zero_data", 128'(rsp_data), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
